iq_avg_decim: RTL
=================

// Module: iq_avg_decim
// PURPOSE
//  Downstream consumer of the lp_2notch interleaved I/Q output. Deinterleaves
//  the 20-bit I/Q stream, averages 2^log2n consecutive complex pairs, and
//  emits one rounded, saturated 18-bit I/Q pair per frame with a valid strobe.
//  Feeds slow readout (local-bus capture, feedback setpoint compare).
// PARAMETERS
//  DW     20  input sample width (signed, matches lp_2notch y)
//  OW     18  output sample width (signed)
//  MAXL    7  max log2n; accumulator width = DW+MAXL
// PORTS
//  clk      in   1      system clock; all logic on posedge
//  rst_n    in   1      asynchronous active-low reset
//  iq       in   1      1: d carries I sample, 0: d carries Q sample
//  d        in   DW     signed interleaved I/Q sample
//  log2n    in   3      frame length = 2^log2n pairs (0..MAXL)
//  sat_clr  in   1      clears sticky sat flag
//  i_out    out  OW     averaged I, held between strobes
//  q_out    out  OW     averaged Q, held between strobes
//  valid    out  1      single-cycle strobe: i_out/q_out updated this cycle
//  sat      out  1      sticky: an output was clipped since last sat_clr
// BEHAVIOUR
//  - Reset (async assert, sync release): i_out=q_out=0, valid=0, sat=0,
//    accumulators=0, pair count=0, state=WAIT_I.
//  - States: WAIT_I (need I), HAVE_I (I held, need Q).
//    WAIT_I, iq=1: hold d as pending I -> HAVE_I.  WAIT_I, iq=0: drop Q, stay.
//    HAVE_I, iq=0: add pending I and d to acc_i/acc_q, count+1 -> WAIT_I.
//    HAVE_I, iq=1: new d replaces pending I, stay (misaligned stream recovers).
//  - log2n latched at first pair of each frame (count==0); a mid-frame change
//    takes effect on the next frame. Values >MAXL clamp to MAXL.
//  - Frame end: pair that makes count==2^L. Next cycle: valid=1,
//    i_out/q_out = sat(round(acc >>> L)); acc and count cleared in the same
//    cycle the final pair is added (no dropped samples at frame boundary).
//    Latency: valid 1 cycle after the completing Q sample.
//  - Rounding: add 2^(L-1) (0 when L=0) before arithmetic shift; half rounds up.
//  - Saturation: result > 2^(OW-1)-1 -> 131071; < -2^(OW-1) -> -131072; sat=1.
//  - sat_clr and a clip in the same cycle: sat stays 1 (set wins).
//  - Accumulators sized DW+MAXL; no internal overflow possible.
//  - Continuous stream of alternating iq: one valid every 2*2^L cycles.
// TESTING
//  1 I=1000,Q=-1000 const, log2n=2 -> valid every 8 clk, i_out=1000,
//    q_out=-1000, sat=0.
//  2 log2n=1, I pairs 3 then 4, Q 0 -> i_out=4 (7+1>>1); I=-3,-4 -> i_out=-3.
//  3 I=524287 const, log2n=0 -> i_out=131071, sat=1; pulse sat_clr with
//    input 0 -> sat=0; sat_clr coincident with clip -> sat=1.
//  4 sequence I,I(=50),Q(=7) with log2n=0 -> one valid, i_out=50, q_out=7;
//    leading stray Q ignored (no valid).
//  5 log2n 2->0 mid-frame -> current frame completes after 4 pairs, then
//    valid every pair; no lost or duplicated samples (compare to model).
//  6 rst_n low mid-frame -> outputs 0 at once; after release first valid
//    after full 2^L fresh pairs, no residue from pre-reset samples.

Source files
------------

// File: rtl/iq_avg_decim.sv
// ----------------------------------------------------------------------------
// iq_avg_decim : deinterleaves an I/Q stream and emits a rounded, saturated
// average of 2^log2n complex pairs per frame with a single-cycle valid strobe.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iq_avg_decim #(
  parameter int DW   = 20,
  parameter int OW   = 18,
  parameter int MAXL = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iq,
  input  logic signed [DW-1:0] d,
  input  logic [2:0]           log2n,
  input  logic                 sat_clr,
  output logic signed [OW-1:0] i_out,
  output logic signed [OW-1:0] q_out,
  output logic                 valid,
  output logic                 sat
);

  localparam int c_AW = DW + MAXL;
  localparam int c_CW = MAXL + 1;
  localparam logic [2:0] c_MAXL = 3'(MAXL);
  localparam logic signed [c_AW:0] c_POS = {{(c_AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [c_AW:0] c_NEG = {{(c_AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  localparam logic [0:0] c_WAIT_I = 1'b0;
  localparam logic [0:0] c_HAVE_I = 1'b1;

  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic                     w_load_i;
  logic                     w_pair;
  logic signed [DW-1:0]     r_pend_i;
  logic signed [c_AW-1:0]   r_acc_i;
  logic signed [c_AW-1:0]   r_acc_q;
  logic [c_CW-1:0]          r_cnt;
  logic [2:0]               r_l;
  logic signed [OW-1:0]     r_i_out;
  logic signed [OW-1:0]     r_q_out;
  logic                     r_valid;
  logic                     r_sat;

  logic [2:0]               w_lreq;
  logic [2:0]               w_l;
  logic [c_CW-1:0]          w_cnt_nxt;
  logic                     w_last;
  logic signed [c_AW-1:0]   w_sum_i;
  logic signed [c_AW-1:0]   w_sum_q;
  logic [OW:0]              w_rs_i;
  logic [OW:0]              w_rs_q;

  // Returns {clipped, value}: round half up, arithmetic shift by l, saturate.
  function automatic logic [OW:0] f_round_sat(input logic signed [c_AW-1:0] acc,
                                              input logic [2:0] l);
    logic signed [c_AW:0] v_ext;
    logic signed [c_AW:0] v_half;
    logic signed [c_AW:0] v_shf;
    v_ext  = {acc[c_AW-1], acc};
    v_half = (l == 3'd0) ? '0 : ((c_AW+1)'(1) << (l - 3'd1));
    v_shf  = (v_ext + v_half) >>> l;
    if (v_shf > c_POS)      f_round_sat = {1'b1, c_POS[OW-1:0]};
    else if (v_shf < c_NEG) f_round_sat = {1'b1, c_NEG[OW-1:0]};
    else                    f_round_sat = {1'b0, v_shf[OW-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_WAIT_I;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_WAIT_I: if (iq)  w_state_nxt = c_HAVE_I;
      c_HAVE_I: if (!iq) w_state_nxt = c_WAIT_I;
      default:           w_state_nxt = c_WAIT_I;
    endcase
  end

  always_comb begin
    w_load_i = iq;
    w_pair   = (r_state == c_HAVE_I) && !iq;
  end

  // Frame length is sampled on the first pair; later pairs use the latched copy.
  assign w_lreq    = (log2n > c_MAXL) ? c_MAXL : log2n;
  assign w_l       = (r_cnt == '0) ? w_lreq : r_l;
  assign w_cnt_nxt = r_cnt + c_CW'(1);
  assign w_last    = (w_cnt_nxt == (c_CW'(1) << w_l));
  assign w_sum_i   = r_acc_i + {{MAXL{r_pend_i[DW-1]}}, r_pend_i};
  assign w_sum_q   = r_acc_q + {{MAXL{d[DW-1]}}, d};
  assign w_rs_i    = f_round_sat(w_sum_i, w_l);
  assign w_rs_q    = f_round_sat(w_sum_q, w_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_i <= '0;
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_cnt    <= '0;
      r_l      <= '0;
      r_i_out  <= '0;
      r_q_out  <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_load_i) r_pend_i <= d;
      if (w_pair) begin
        if (r_cnt == '0) r_l <= w_lreq;
        if (w_last) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_cnt   <= '0;
          r_i_out <= w_rs_i[OW-1:0];
          r_q_out <= w_rs_q[OW-1:0];
          r_valid <= 1'b1;
        end else begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
          r_cnt   <= w_cnt_nxt;
        end
      end
      // A clip in the same cycle as sat_clr keeps the flag set.
      if (w_pair && w_last && (w_rs_i[OW] || w_rs_q[OW])) r_sat <= 1'b1;
      else if (sat_clr)                                    r_sat <= 1'b0;
    end
  end

  assign i_out = r_i_out;
  assign q_out = r_q_out;
  assign valid = r_valid;
  assign sat   = r_sat;

endmodule

`default_nettype wire
